mult_unit: RTL and testbench
============================

# mult_unit

Iterative 32x32 shift-and-add multiplier for the ALU, implementing MIPS `mult`/`multu` into a 64-bit HI/LO result. Each iteration produces one 33-bit partial sum (32-bit sum plus carry-out) with the same arithmetic as the ALU's 32-bit adder. The unit accepts operands from the ALU operand stage and hands HI/LO to the HI/LO register write path. Latency is fixed, and one operation runs at a time.

## Interface

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the iteration counter is sized to log2(WIDTH)+1 bits.

Ports:
- clk, in, 1, rising-edge clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, request a multiply; sampled only in IDLE
- is_signed, in, 1, 1 = `mult` (two's complement), 0 = `multu`; captured with start
- x, in, WIDTH, multiplicand; captured with start
- y, in, WIDTH, multiplier; captured with start
- busy, out, 1, high while an operation is in flight (CALC, NEG)
- done, out, 1, one-cycle pulse when hi/lo are valid
- hi, out, WIDTH, product bits [63:32]
- lo, out, WIDTH, product bits [31:0]

## Operation

- States: IDLE, CALC, NEG.
- **Reset** (rst high at a clock edge), any state: state goes to IDLE; busy=0, done=0, hi=0, lo=0, counter=0, internal registers=0. Reset overrides start.
- **IDLE**, start=1:
  - Latch operands. If is_signed, latch |x| and |y| as 32-bit unsigned magnitudes (-2^31 gives magnitude 0x80000000) and neg = x[31]^y[31]. Otherwise latch x and y unchanged, neg=0.
  - Load acc=0, mq=|y|, mcand=|x|, count=0; go to CALC.
- **IDLE**, start=0: hold. hi/lo keep the last result.
- **CALC**, one iteration per clock:
  - {c, s} = acc + (mq[0] ? mcand : 0), giving a 33-bit result.
  - {acc, mq} = {c, s, mq} >> 1, dropping the LSB.
  - count increments. After the iteration with count=31, go to NEG.
- **NEG**, one cycle, always taken (even when unsigned) so latency stays fixed:
  - If neg=1, {hi, lo} = -{acc, mq} as a 64-bit two's complement.
  - Otherwise {hi, lo} = {acc, mq}.
  - Assert done for the next cycle and go to IDLE.
- start while busy: ignored, no queuing. Changes to x, y or is_signed after capture have no effect.
- hi/lo change only on the NEG edge or on reset. They are never partially updated during CALC.

## Timing

- Start accepted at edge t0: busy=1 from after t0 until t33. CALC iterations run at edges t1..t32; NEG runs at edge t33.
- After t33: done=1 for exactly one cycle, busy=0, and hi/lo hold the final product.
- The cycle where done=1 is an IDLE cycle, so start can be accepted at the following edge. Back-to-back throughput is one op per 34 cycles.
- done and busy are never high together.
- rst asserted mid-CALC or mid-NEG: the operation is aborted, no done pulse is produced, and outputs reach their reset values after that edge.
- Outputs are registered. There is no combinational path from inputs to outputs.
- Width rules:
  - Partial sum is 33 bits, and the carry shifts into acc[31].
  - The final product is exactly 64 bits, with no overflow flag. MIPS mult does not trap.

## Test plan

- **Unsigned max**: multu x=0xFFFFFFFF, y=0xFFFFFFFF -> done exactly 33 cycles after the accept edge; hi=0xFFFFFFFE, lo=0x00000001. busy high for the 33 intervening cycles.
- **Signed mixed signs**:
  - mult x=0xFFFFFFFD (-3), y=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - mult x=-1, y=-1 -> hi=0, lo=1.
  - Same -1, -1 operands as multu -> hi=0xFFFFFFFE, lo=0x00000001.
- **Signed corner**:
  - mult x=y=0x80000000 -> hi=0x40000000, lo=0.
  - mult x=0x80000000, y=1 -> hi=0xFFFFFFFF, lo=0x80000000.
  - 0 times any value -> hi=lo=0.
- **Ignored start and operand changes**: pulse start with x=7, y=9, then re-assert start with x=2, y=2 and toggle x/y every cycle while busy -> a single done, hi=0, lo=63, and no second operation.
- **Reset mid-op**: assert rst at CALC iteration 10 for one cycle -> busy=0, done=0, hi=lo=0 after that edge, and no done pulse follows. A new start then completes normally.
- **Back-to-back**: assert start in the done cycle (x=3, y=4) -> accepted; the next done comes 33 cycles later with lo=12, hi=0. The previous result holds on hi/lo until the new NEG edge.

Source files
------------

// File: rtl/mult_unit_if.sv
// -----------------------------------------------------------------------------
// mult_unit_if
//
// Purpose:
//   Bundles the request/response signals of the iterative multiplier so the
//   ALU operand stage (master) and the multiplier (slave) share one port.
//
// Signals:
//   start     - master -> slave, request a multiply (only honoured when idle)
//   is_signed - master -> slave, 1 = mult (two's complement), 0 = multu
//   x, y      - master -> slave, multiplicand and multiplier
//   busy      - slave -> master, operation in flight
//   done      - slave -> master, one-cycle pulse when hi/lo hold a new product
//   hi, lo    - slave -> master, upper and lower halves of the 64-bit product
// -----------------------------------------------------------------------------
interface mult_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Operand stage side: issues requests and consumes the product.
  modport master (
    output start,
    output is_signed,
    output x,
    output y,
    input  busy,
    input  done,
    input  hi,
    input  lo
  );

  // Multiplier side: accepts requests and returns the product.
  modport slave (
    input  start,
    input  is_signed,
    input  x,
    input  y,
    output busy,
    output done,
    output hi,
    output lo
  );

endinterface

// File: rtl/mult_unit.sv
// -----------------------------------------------------------------------------
// mult_unit
//
// Purpose:
//   Iterative shift-and-add multiplier implementing MIPS mult/multu. Signed
//   operands are converted to magnitudes on capture, an unsigned 32x32
//   product is built one bit per clock, and a final cycle applies the sign.
//   Latency is fixed at 33 clocks from the accept edge to the hi/lo update,
//   regardless of operand values or signedness.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, aborts any operation in flight
//   bus  - mult_unit_if.slave: start/is_signed/x/y in, busy/done/hi/lo out
//
// Parameters:
//   WIDTH - operand width; only 32 is supported
// -----------------------------------------------------------------------------
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mult_unit_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] mq_q,    mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q,   neg_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0]   x_mag;
  logic [WIDTH-1:0]   y_mag;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_neg;

  // Operand magnitudes for a signed request. Negating -2^31 wraps back to
  // 0x80000000, which is the correct unsigned magnitude, so no special case.
  always_comb begin
    x_mag = bus.x;
    y_mag = bus.y;
    if (bus.is_signed && bus.x[WIDTH-1]) begin
      x_mag = -bus.x;
    end
    if (bus.is_signed && bus.y[WIDTH-1]) begin
      y_mag = -bus.y;
    end
  end

  // One partial sum per iteration: the accumulator plus the multiplicand
  // gated by the current multiplier bit. The extra top bit keeps the carry so
  // it can shift back into the accumulator MSB.
  always_comb begin
    partial     = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mcand_q : '0)};
    product     = {acc_q, mq_q};
    product_neg = -product;
  end

  // Next-state and datapath control. Every register holds by default; only
  // the state that owns a register changes it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    neg_d   = neg_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          mq_d    = y_mag;
          mcand_d = x_mag;
          count_d = '0;
          neg_d   = bus.is_signed & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
          state_d = CALC;
        end
      end

      CALC: begin
        // The low product bits leave the partial sum through the bottom of
        // mq while the consumed multiplier bit drops out of its LSB.
        acc_d   = partial[WIDTH:1];
        mq_d    = {partial[0], mq_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = NEG;
        end
      end

      NEG: begin
        // Taken even for unsigned operations so the latency never varies.
        if (neg_q) begin
          {hi_d, lo_d} = product_neg;
        end else begin
          {hi_d, lo_d} = product;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, including the
  // last product, and wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers; busy is a decode of the state
  // register, so it cannot overlap the done pulse, which is an IDLE cycle.
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_unit
//
// Purpose:
//   Self-checking bench for mult_unit. Directed vectors come from a table of
//   hand-computed products, corner sequences (ignored start, reset mid-op,
//   back-to-back) are written out explicitly, and random operands are checked
//   against a plain 64-bit arithmetic reference.
// -----------------------------------------------------------------------------
module tb_mult_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;

  mult_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_prod;

  typedef struct {
    string       name;
    logic        is_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] expected;
  } vec_t;

  vec_t vecs[9];

  // Reference product from ordinary 64-bit arithmetic on the raw operands.
  function automatic logic [63:0] ref_product(input logic s, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (s) return 64'(sa * sb);
    return ua * ub;
  endfunction

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present a request for exactly one clock edge (the accept edge).
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.x         = a;
    bus.y         = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Sample every cycle after the accept edge until done, bounded at 40
  // cycles. n counts clock edges since the accept edge.
  task automatic waitDone(input logic [63:0] prev, output int latency,
                          output int bad_busy, output int bad_hold);
    latency  = -1;
    bad_busy = 0;
    bad_hold = 0;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        latency = n;
        if (bus.busy) bad_busy++;
        break;
      end
      if (!bus.busy) bad_busy++;
      if ({bus.hi, bus.lo} !== prev) bad_hold++;
    end
  endtask

  // Full operation: issue, wait, check timing, hold behaviour and product.
  // Returns in the done cycle so a caller can start the next op immediately.
  task automatic runAndCheck(input string name, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] expected);
    int lat;
    int bad_busy;
    int bad_hold;
    applyStimulus(s, a, b);
    waitDone(last_prod, lat, bad_busy, bad_hold);
    checkOutput({name, " latency"}, 64'(lat), 64'd33);
    checkOutput({name, " busy"}, 64'(bad_busy), 64'd0);
    checkOutput({name, " hold"}, 64'(bad_hold), 64'd0);
    checkOutput({name, " hi"}, {32'b0, bus.hi}, {32'b0, expected[63:32]});
    checkOutput({name, " lo"}, {32'b0, bus.lo}, {32'b0, expected[31:0]});
    last_prod = expected;
  endtask

  initial begin
    int          lat;
    int          done_count;
    int          overlap;
    int          busy_seen;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0] = '{"umax",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{"neg3x5",    1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{"sm1xm1",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[3] = '{"um1xm1",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[4] = '{"minxmin",   1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[5] = '{"minx1",     1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{"zero_s",    1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
    vecs[7] = '{"zero_u",    1'b0, 32'hCAFE_F00D, 32'h0000_0000, 64'h0};
    vecs[8] = '{"pos_x_neg", 1'b1, 32'h0001_0000, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFE_0000};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    last_prod     = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", {63'b0, bus.busy}, 64'd0);
    checkOutput("reset done", {63'b0, bus.done}, 64'd0);
    checkOutput("reset hi", {32'b0, bus.hi}, 64'd0);
    checkOutput("reset lo", {32'b0, bus.lo}, 64'd0);

    // Directed table; done must drop again one cycle after its pulse.
    for (int i = 0; i < 9; i++) begin
      runAndCheck(vecs[i].name, vecs[i].is_signed, vecs[i].x, vecs[i].y, vecs[i].expected);
      @(negedge clk);
      checkOutput({vecs[i].name, " done pulse"}, {63'b0, bus.done}, 64'd0);
    end

    // Start held and operands toggled while busy: only the first op counts.
    $display("[TB] ignored start sequence");
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.x         = 32'd7;
    bus.y         = 32'd9;
    @(posedge clk);
    #1;
    done_count = 0;
    overlap    = 0;
    lat        = -1;
    for (int n = 0; n < 76; n++) begin
      @(negedge clk);
      if (bus.done) begin
        done_count++;
        if (lat < 0) lat = n;
      end
      if (bus.done && bus.busy) overlap++;
      if (n < 32) begin
        bus.start     = 1'b1;
        bus.is_signed = n[0];
        bus.x         = n[0] ? 32'hFFFF_FFF0 : 32'd2;
        bus.y         = n[0] ? 32'h1234_5678 : 32'd2;
      end else begin
        bus.start = 1'b0;
      end
    end
    checkOutput("ignore done count", 64'(done_count), 64'd1);
    checkOutput("ignore latency", 64'(lat), 64'd33);
    checkOutput("ignore overlap", 64'(overlap), 64'd0);
    checkOutput("ignore hi", {32'b0, bus.hi}, 64'd0);
    checkOutput("ignore lo", {32'b0, bus.lo}, 64'd63);
    last_prod = 64'd63;

    // Reset during CALC aborts the op and clears the previous result.
    $display("[TB] reset mid-op sequence");
    applyStimulus(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int n = 0; n < 10; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst busy", {63'b0, bus.busy}, 64'd0);
    checkOutput("midrst done", {63'b0, bus.done}, 64'd0);
    checkOutput("midrst hi", {32'b0, bus.hi}, 64'd0);
    checkOutput("midrst lo", {32'b0, bus.lo}, 64'd0);
    done_count = 0;
    busy_seen  = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) done_count++;
      if (bus.busy) busy_seen++;
    end
    checkOutput("midrst no done", 64'(done_count), 64'd0);
    checkOutput("midrst stays idle", 64'(busy_seen), 64'd0);
    last_prod = '0;
    runAndCheck("after reset", 1'b1, 32'hFFFF_FF00, 32'h0000_0100,
                ref_product(1'b1, 32'hFFFF_FF00, 32'h0000_0100));

    // Back-to-back: the next start is presented in the done cycle itself.
    runAndCheck("b2b first", 1'b0, 32'h0001_2345, 32'h0006_7890,
                ref_product(1'b0, 32'h0001_2345, 32'h0006_7890));
    runAndCheck("b2b second", 1'b0, 32'd3, 32'd4, 64'd12);
    @(negedge clk);

    // Random operands against the arithmetic reference, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i % 6 == 0) a = 32'h8000_0000;
      if (i % 6 == 3) b = 32'hFFFF_FFFF;
      runAndCheck($sformatf("random %0d", i), s, a, b, ref_product(s, a, b));
      if (i % 2 == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
